// File: rtl/updown_sweep_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : updown_sweep_ctrl_pkg
// Desc     : State encodings and direction constants for the sweep controller.
// Revision : 1.0
// ============================================================================
package updown_sweep_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_RUN  = 3'd2,
    ST_TURN = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  localparam logic c_DIR_UP   = 1'b1;
  localparam logic c_DIR_DOWN = 1'b0;

endpackage
`default_nettype wire

// File: rtl/sweep_target_unit.sv
`default_nettype none
// ============================================================================
// Module   : sweep_target_unit
// Desc     : Holds the current leg target and direction, and flags arrival.
// Revision : 1.0
// ============================================================================
module sweep_target_unit
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_turn,
  input  logic [WIDTH-1:0] i_start,
  input  logic [WIDTH-1:0] i_stop,
  input  logic [WIDTH-1:0] i_value,
  output logic             o_dir,
  output logic             o_match
);

  logic [WIDTH-1:0] r_target;
  logic             r_dir;

  // Direction always points toward the target, so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_target <= '0;
      r_dir    <= c_DIR_DOWN;
    end else if (i_load) begin
      r_target <= i_stop;
      r_dir    <= (i_stop >= i_start) ? c_DIR_UP : c_DIR_DOWN;
    end else if (i_turn) begin
      r_target <= i_start;
      r_dir    <= ~r_dir;
    end
  end

  assign o_dir   = r_dir;
  assign o_match = (i_value == r_target);

endmodule
`default_nettype wire

// File: rtl/updown_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : updown_sweep_ctrl
// Desc     : Command-driven sequencer sweeping an external up/down counter.
// Revision : 1.0
// ============================================================================
module updown_sweep_ctrl
  import updown_sweep_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [WIDTH-1:0] i_cmd_start,
  input  logic [WIDTH-1:0] i_cmd_stop,
  input  logic             i_cmd_pingpong,
  input  logic [REP_W-1:0] i_cmd_reps,
  input  logic             i_abort,
  output logic             o_cnt_load,
  output logic [WIDTH-1:0] o_cnt_data,
  output logic             o_cnt_en,
  output logic             o_cnt_up,
  input  logic [WIDTH-1:0] i_cnt_value,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_aborted,
  output logic [REP_W-1:0] o_reps_left
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_start;
  logic [WIDTH-1:0] r_stop;
  logic             r_pp;
  logic             r_ret;
  logic [REP_W-1:0] r_reps;
  logic             r_aborted;

  logic w_accept;
  logic w_abort;
  logic w_match;
  logic w_dir;
  logic w_to_turn;
  logic w_dec;

  sweep_target_unit #(.WIDTH(WIDTH)) u_target (
    .clk     (clk),
    .rst     (rst),
    .i_load  (r_state == ST_LOAD),
    .i_turn  (r_state == ST_TURN),
    .i_start (r_start),
    .i_stop  (r_stop),
    .i_value (i_cnt_value),
    .o_dir   (w_dir),
    .o_match (w_match)
  );

  assign w_accept  = i_cmd_valid & (r_state == ST_IDLE);
  assign w_abort   = i_abort & ((r_state == ST_LOAD) | (r_state == ST_RUN) | (r_state == ST_TURN));
  assign w_to_turn = r_pp & ~r_ret;
  assign w_dec     = (r_state == ST_RUN) & w_match & ~w_to_turn & (r_reps > REP_W'(1)) & ~w_abort;

  always_comb begin
    w_next   = r_state;
    o_cnt_en = 1'b0;
    o_cnt_up = 1'b0;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_LOAD;
      ST_LOAD: begin
        o_cnt_up = (r_stop >= r_start);
        w_next   = ST_RUN;
      end
      ST_RUN: begin
        o_cnt_up = w_dir;
        if (w_match) begin
          if (w_to_turn)                   w_next = ST_TURN;
          else if (r_reps > REP_W'(1))     w_next = ST_LOAD;
          else                             w_next = ST_DONE;
        end else begin
          o_cnt_en = 1'b1;
        end
      end
      ST_TURN: begin
        o_cnt_up = w_dir;
        w_next   = ST_RUN;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (w_abort) begin
      w_next   = ST_DONE;
      o_cnt_en = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_start   <= '0;
      r_stop    <= '0;
      r_pp      <= 1'b0;
      r_ret     <= 1'b0;
      r_reps    <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_start <= i_cmd_start;
        r_stop  <= i_cmd_stop;
        r_pp    <= i_cmd_pingpong;
        r_reps  <= (i_cmd_reps == '0) ? REP_W'(1) : i_cmd_reps;
      end
      if (r_state == ST_LOAD) r_ret <= 1'b0;
      if (r_state == ST_TURN) r_ret <= 1'b1;
      if (w_dec) r_reps <= r_reps - REP_W'(1);
      if (w_abort)                    r_aborted <= 1'b1;
      else if (r_state == ST_DONE)    r_aborted <= 1'b0;
    end
  end

  assign o_cmd_ready = (r_state == ST_IDLE);
  assign o_busy      = (r_state != ST_IDLE);
  assign o_done      = (r_state == ST_DONE);
  assign o_aborted   = r_aborted;
  assign o_cnt_load  = (r_state == ST_LOAD);
  assign o_cnt_data  = (r_state == ST_LOAD) ? r_start : '0;
  assign o_reps_left = r_reps;

endmodule
`default_nettype wire

// File: doc/updown_sweep_ctrl.md
Name: updown_sweep_ctrl

Overview:
- Command-driven sequencer that programs and steps an external WIDTH-bit loadable up/down counter through sweeps from a start value to a stop value.
- Supports single-direction sweeps or ping-pong sweeps (start→stop→start), repeated a programmed number of times.
- Sits between a command source (valid/ready) and the counter's load/enable/up_down/data_in inputs. It watches the counter's count_out as feedback.

Parameters:
- WIDTH, 4, counter data width; must match the controlled counter.
- REP_W, 4, width of the repeat-count field.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE; command is accepted when cmd_valid & cmd_ready.
- cmd_start  in  WIDTH  sweep start value.
- cmd_stop  in  WIDTH  sweep stop value.
- cmd_pingpong  in  1  1 = each sweep runs start→stop→start.
- cmd_reps  in  REP_W  number of sweeps; 0 is treated as 1.
- abort  in  1  terminates the active command.
- cnt_load  out  1  drives counter load.
- cnt_data  out  WIDTH  drives counter data_in.
- cnt_en  out  1  drives counter enable.
- cnt_up  out  1  drives counter up_down (1 = up).
- cnt_value  in  WIDTH  counter count_out feedback; registered, updates one cycle after cnt_en or cnt_load.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse, high in DONE.
- aborted  out  1  valid while done = 1; set if the command ended by abort.
- reps_left  out  REP_W  sweeps remaining, including the current sweep.

Behaviour:
- Reset values (asynchronous, take effect immediately on rst):
  - state = IDLE, so cmd_ready = 1.
  - busy, done, aborted, cnt_load, cnt_en, cnt_up = 0.
  - cnt_data = 0, reps_left = 0.
  - All captured command registers = 0.
- States: IDLE, LOAD, RUN, TURN, DONE.
- Outputs are Moore, except cnt_en, which is combinational from the state, the target register, cnt_value and abort.
- IDLE:
  - On accept, capture start, stop, pingpong and reps (0 → 1) into reps_left; go to LOAD.
  - abort is ignored in IDLE, including when it is coincident with cmd_valid.
- LOAD (1 cycle):
  - cnt_load = 1, cnt_data = start.
  - target = stop; dir = (stop >= start); cnt_up = dir.
  - Next state is RUN.
- RUN:
  - cnt_up = dir; cnt_en = (cnt_value != target) & ~abort.
  - When cnt_value == target, the sweep leg is complete:
    - If pingpong and this was the outbound leg, go to TURN.
    - Otherwise, if reps_left == 1, go to DONE. If reps_left > 1, decrement reps_left and go to LOAD.
- TURN (1 cycle):
  - cnt_en = 0, target = start, dir = ~dir.
  - Next state is RUN (return leg).
- DONE (1 cycle):
  - done = 1, busy = 1, then go to IDLE.
  - A new command can be accepted on the following cycle at the earliest.
- Abort: in LOAD, RUN or TURN, abort forces cnt_en = 0 that cycle and moves to DONE with aborted = 1. aborted clears on the return to IDLE.
- start == stop: the LOAD then RUN path detects a match on the first RUN cycle. Zero steps are issued.
  - Ping-pong still passes through TURN.
  - Each sweep costs 2 cycles non-pingpong, 4 cycles pingpong.
- Wrap-around:
  - Direction is always chosen toward the target, so the counter never wraps. co is not used.
  - start = 2^WIDTH−1 with stop = 0 counts down.
- Timing, non-pingpong, reps = 1, accept at cycle T:
  - LOAD at T+1; cnt_value = start at T+2.
  - Match at T+2+|stop−start|; done at T+3+|stop−start|.
- Captured command registers are not affected by input changes after accept.
- rst mid-operation: immediate return to IDLE with reset values. The counter shares rst.

Decomposition:
- Shared package/header: state encodings (IDLE=0, LOAD=1, RUN=2, TURN=3, DONE=4, 3-bit) and a DIR_UP/DIR_DOWN constant.
- One natural sub-module: sweep_target_unit. It holds the target and dir registers, performs the swap on TURN, and produces the match = (cnt_value == target) comparison.
- The FSM and reps_left stay in the top module.
- The bench instantiates the team's up/down counter as the controlled model.

Test Plan:
- Up sweep: start=2, stop=5, pingpong=0, reps=1, accept at T → cnt_load at T+1 with data 2; cnt_en high for cnt_value 2,3,4; match at T+5; done at T+6; cmd_ready again at T+7.
- Down ping-pong: start=9, stop=6, pingpong=1, reps=1 → cnt_up=0 outbound, counter 9→6; TURN cycle with cnt_en=0; cnt_up=1 return leg, 6→9; done with aborted=0.
- Repeats: start=0, stop=3, reps=3 → three LOAD pulses; reps_left reads 3, 2, 1; done once, after the third match. reps=0 behaves as reps=1.
- Boundary: start=stop=15, reps=1 → cnt_en never high; done at T+3.
- Extreme range: start=15, stop=0 → 15 down-steps with no wrap.
- Abort: abort asserted mid-RUN at cnt_value=4 of a 2→10 sweep → cnt_en low that cycle; counter holds 4; done with aborted=1 next cycle.
- Abort in IDLE coincident with a valid command → command accepted normally.
- Reset mid-TURN → busy=0 and cmd_ready=1 immediately; all counter control outputs 0.
